mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/rr_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared FSM encoding, default widths and requester select codes for the memory port arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mem_port_arbiter_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    // Requester select encoding used by sel and last_sel
    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // An address is out of range when any bit above the memory index is set
    function automatic logic addr_oor(input logic [31:0] addr, input int aw);
        return (addr >> aw) != 32'd0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: two-way round-robin picker between fetch and data requesters.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_sel,
    output logic any,
    output logic pick
);

    // On a tie serve whoever was not served last, otherwise the sole requester
    always_comb begin
        any = if_req | d_req;
        if (if_req && d_req) begin
            pick = ~last_sel;
        end else if (d_req) begin
            pick = SEL_DATA;
        end else begin
            pick = SEL_FETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between a fetch port and a load/store port.
// Latency: request sampled at edge N, mem access in cycle N+1, valid pulse in cycle N+2.
// Backpressure: requests are held by the requester until valid; loser waits in IDLE.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t        state;
    state_t        state_nxt;
    logic          sel;
    logic          last_sel;
    logic          lat_we;
    logic          lat_oor;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic [DW-1:0] resp_data;
    logic          any;
    logic          pick;

    rr_pick u_rr_pick (
        .if_req   (if_req),
        .d_req    (d_req),
        .last_sel (last_sel),
        .any      (any),
        .pick     (pick)
    );

    // Stores and rejected accesses complete with a zero read value
    assign resp_data = (lat_oor || lat_we) ? '0 : mem_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: requests are only looked at in IDLE, the rest is a fixed walk
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (any) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winning request at the grant; last_sel starts as data so fetch wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            sel       <= SEL_FETCH;
            last_sel  <= SEL_DATA;
            lat_we    <= 1'b0;
            lat_oor   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == ST_IDLE && any) begin
            sel      <= pick;
            last_sel <= pick;
            if (pick == SEL_DATA) begin
                lat_we    <= d_we;
                lat_oor   <= addr_oor(d_addr, AW);
                lat_addr  <= d_addr[AW-1:0];
                lat_wdata <= d_wdata;
            end else begin
                lat_we    <= 1'b0;
                lat_oor   <= addr_oor(if_addr, AW);
                lat_addr  <= if_addr[AW-1:0];
                lat_wdata <= '0;
            end
        end
    end

    // Keep each requester's last result visible until its next completion
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (state == ST_RESP) begin
            if (sel == SEL_DATA) begin
                d_rdata_q <= resp_data;
            end else begin
                if_rdata_q <= resp_data;
            end
        end
    end

    // Outputs decoded from state; read data is passed straight through during RESP
    always_comb begin
        busy      = (state != ST_IDLE);
        if_gnt    = busy && (sel == SEL_FETCH);
        d_gnt     = busy && (sel == SEL_DATA);
        mem_en    = (state == ST_ACCESS) && !lat_oor;
        mem_we    = (state == ST_ACCESS) && !lat_oor && lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if_valid  = (state == ST_RESP) && (sel == SEL_FETCH);
        d_valid   = (state == ST_RESP) && (sel == SEL_DATA);
        if_err    = if_valid && lat_oor;
        d_err     = d_valid && lat_oor;
        if_rdata  = if_valid ? resp_data : if_rdata_q;
        d_rdata   = d_valid ? resp_data : d_rdata_q;
    end

endmodule
